// File: rtl/spi_sram_pkg.sv
// Shared definitions for the SPI SRAM arbiter and its serial engine.
// Holds the SPI command opcodes, the frame geometry, the engine state
// encoding and a helper that assembles the 40-bit {cmd, addr, wdata} frame.
package spi_sram_pkg;

    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam logic [7:0] CMD_WRITE = 8'h02;
    localparam int         ADDR_W    = 24;
    localparam int         XFER_BITS = 40;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        HIGH,
        LOW,
        GAP
    } spi_state_t;

    // Command and address go out for both directions; for reads the data
    // byte is simply clocked out as filler while the SRAM drives miso.
    function automatic logic [XFER_BITS-1:0] build_frame(
        input logic              wr,
        input logic [ADDR_W-1:0] addr,
        input logic [7:0]        wdata
    );
        return {(wr ? CMD_WRITE : CMD_READ), addr, wdata};
    endfunction

endpackage

// File: rtl/spi_byte_xfer.sv
// SPI mode-0 single-byte transfer engine (SELECT/HIGH/LOW/GAP).
// Ports:
//   clk, rst      system clock, async active-high reset
//   start         accepted only while ready; latches frame and selects the SRAM
//   frame         40-bit {cmd, addr, wdata}, shifted out MSB first
//   ready         engine is in IDLE and can take a start
//   done          one-cycle pulse on the edge that completes bit 39
//   rdata         last 8 bits sampled from miso, held until the next data phase
//   cs_n, mosi, sclk, miso   SPI pins; sclk = clk/2 while selected, idle low
module spi_byte_xfer
    import spi_sram_pkg::*;
#(
    parameter int CS_GAP = 1    // legal range 1..15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [XFER_BITS-1:0] frame,
    input  logic                 miso,
    output logic                 ready,
    output logic                 done,
    output logic [7:0]           rdata,
    output logic                 cs_n,
    output logic                 mosi,
    output logic                 sclk
);

    localparam logic [5:0] LAST_BIT  = 6'(XFER_BITS - 1);
    localparam logic [5:0] DATA_BIT0 = 6'(XFER_BITS - 8);
    localparam logic [5:0] GAP_LAST  = 6'(CS_GAP - 1);

    spi_state_t           state, state_nx;
    logic [XFER_BITS-1:0] shreg;
    logic [5:0]           cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // HIGH -> LOW is the sclk falling edge, so shifting, sampling and the
    // bit count all happen on that transition. The last bit goes straight
    // from HIGH to GAP, which is where cs_n rises.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = SELECT;
            SELECT:  state_nx = HIGH;
            HIGH:    state_nx = (cnt == LAST_BIT) ? GAP : LOW;
            LOW:     state_nx = HIGH;
            GAP:     if (cnt == GAP_LAST) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign ready = (state == IDLE);
    // After 40 shifts the register is all zero, so mosi idles low for free.
    assign mosi  = shreg[XFER_BITS-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg <= '0;
            cnt   <= '0;
            rdata <= '0;
            done  <= 1'b0;
            cs_n  <= 1'b1;
            sclk  <= 1'b0;
        end else begin
            done <= 1'b0;
            // Pins are registered from the next state so they never glitch.
            cs_n <= !(state_nx == SELECT || state_nx == HIGH || state_nx == LOW);
            sclk <= (state_nx == HIGH);
            case (state)
                IDLE: begin
                    if (start) begin
                        shreg <= frame;
                        cnt   <= '0;
                    end
                end
                HIGH: begin
                    shreg <= {shreg[XFER_BITS-2:0], 1'b0};
                    if (cnt >= DATA_BIT0) rdata <= {rdata[6:0], miso};
                    // The bit counter is recycled as the GAP cycle counter.
                    if (cnt == LAST_BIT) begin
                        cnt  <= '0;
                        done <= 1'b1;
                    end else begin
                        cnt <= cnt + 6'd1;
                    end
                end
                GAP:     cnt <= cnt + 6'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/spi_sram_arbiter.sv
// Two-port round-robin arbiter in front of the SPI SRAM byte engine.
// Port 0 is the cache-fill port, port 1 the auxiliary requester.
// Ports:
//   clk, rst                 system clock, async active-high reset
//   req0/1, wr0/1            request (held until ack), 1 = write
//   addr0/1, wdata0/1        24-bit byte address, write byte
//   ack0/1                   one-cycle completion pulse for the granted port
//   rdata                    read byte, valid with ack
//   cs_n, mosi, sclk, miso   SPI SRAM pins
module spi_sram_arbiter
    import spi_sram_pkg::*;
#(
    parameter int CS_GAP = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              wr0,
    input  logic              wr1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [7:0]        wdata0,
    input  logic [7:0]        wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [7:0]        rdata,
    output logic              cs_n,
    output logic              mosi,
    output logic              sclk,
    input  logic              miso
);

    logic                 ready, start, done, winner;
    logic                 last_grant;
    logic [XFER_BITS-1:0] frame;

    // Requests only matter while the engine is idle; the engine latches the
    // frame on the granting edge, so later changes to addr/wr/wdata are ignored.
    always_comb begin
        if (req0 && req1) winner = ~last_grant;
        else              winner = req1;
        start = ready && (req0 || req1);
        frame = winner ? build_frame(wr1, addr1, wdata1)
                       : build_frame(wr0, addr0, wdata0);
    end

    // last_grant doubles as the latched port id for steering the ack; it
    // cannot change until the engine is idle again, after done has fired.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)        last_grant <= 1'b1;
        else if (start) last_grant <= winner;
    end

    assign ack0 = done && !last_grant;
    assign ack1 = done &&  last_grant;

    spi_byte_xfer #(.CS_GAP(CS_GAP)) u_xfer (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .frame (frame),
        .miso  (miso),
        .ready (ready),
        .done  (done),
        .rdata (rdata),
        .cs_n  (cs_n),
        .mosi  (mosi),
        .sclk  (sclk)
    );

endmodule

// File: tb/tb_spi_sram_arbiter.sv
// Directed bench for spi_sram_arbiter with a pin-level SPI SRAM model.
module tb_spi_sram_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0, wr0 = 1'b0, wr1 = 1'b0;
    logic [23:0] addr0 = '0, addr1 = '0;
    logic [7:0]  wdata0 = '0, wdata1 = '0;
    logic        ack0, ack1, cs_n, mosi, sclk;
    logic [7:0]  rdata;
    logic        miso = 1'b0;

    int checks = 0;
    int failures = 0;

    spi_sram_arbiter #(.CS_GAP(1)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata(rdata),
        .cs_n(cs_n), .mosi(mosi), .sclk(sclk), .miso(miso)
    );

    always #5 clk = ~clk;

    // SPI SRAM model: mode 0, samples mosi on sclk rise, drives miso after
    // each sclk fall once 32 command/address bits are in. Writes commit only
    // when cs_n rises after a complete 40-bit frame.
    logic [7:0]  mem [logic [23:0]];
    logic [39:0] rx = '0;
    logic [39:0] last_frame = '0;
    logic [7:0]  rd = '0;
    logic        m_cs = 1'b1, m_sclk = 1'b0;
    int          nb = 0;

    always @(sclk or cs_n) begin
        if (cs_n !== m_cs) begin
            if (cs_n === 1'b0) nb = 0;
            else if (cs_n === 1'b1 && nb == 40) begin
                last_frame = rx;
                if (rx[39:32] == 8'h02) mem[rx[31:8]] = rx[7:0];
            end
            m_cs = cs_n;
        end
        if (sclk !== m_sclk) begin
            if (cs_n === 1'b0 && sclk === 1'b1) begin
                rx = {rx[38:0], mosi};
                nb++;
            end else if (cs_n === 1'b0 && sclk === 1'b0 && nb >= 32 && nb < 40) begin
                if (nb == 32)
                    rd = (rx[31:24] == 8'h03 && mem.exists(rx[23:0])) ? mem[rx[23:0]] : 8'h00;
                miso = rd[7 - (nb - 32)];
            end
            m_sclk = sclk;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Results of the most recent run() call.
    int         grants[$];
    int         falls[$];
    int         lat[$];
    logic [7:0] rd_q[$];
    int         min_hi;

    // Drives both requesters: raise, drop on ack, re-raise next cycle while
    // more requests remain. With hold set a port keeps req high across acks.
    task automatic run(input int n0, input int n1, input bit hold);
        int   left0 = n0;
        int   left1 = n1;
        int   c = 0;
        int   hi = 0;
        logic prev_cs = 1'b1;
        grants.delete(); falls.delete(); lat.delete(); rd_q.delete();
        min_hi = 1000;
        while ((left0 > 0 || left1 > 0) && c < 2000) begin
            @(negedge clk);
            c++;
            if (prev_cs && !cs_n) begin
                falls.push_back(c);
                if (falls.size() > 1 && hi < min_hi) min_hi = hi;
                hi = 0;
            end
            if (cs_n) hi++;
            prev_cs = cs_n;
            if (ack0) begin
                grants.push_back(0); lat.push_back(c - falls[$]); rd_q.push_back(rdata);
                left0--;
                if (!hold || left0 == 0) req0 = 1'b0;
            end else if (left0 > 0) req0 = 1'b1;
            if (ack1) begin
                grants.push_back(1); lat.push_back(c - falls[$]); rd_q.push_back(rdata);
                left1--;
                if (!hold || left1 == 0) req1 = 1'b0;
            end else if (left1 > 0) req1 = 1'b1;
        end
        req0 = 1'b0;
        req1 = 1'b0;
        chk("run_in_budget", 64'(c < 2000), 64'(1));
    endtask

    initial begin : main
        int         c;
        logic [3:0] order;
        logic [39:0] f;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_cs_n",  64'(cs_n),  64'(1));
        chk("rst_sclk",  64'(sclk),  64'(0));
        chk("rst_mosi",  64'(mosi),  64'(0));
        chk("rst_ack0",  64'(ack0),  64'(0));
        chk("rst_ack1",  64'(ack1),  64'(0));
        chk("rst_rdata", 64'(rdata), 64'(0));
        rst = 1'b0;

        // Write via port 0
        wr0 = 1'b1; addr0 = 24'h001234; wdata0 = 8'hA5;
        run(1, 0, 0);
        chk("wr_grant",   64'(grants.size() == 1 && grants[0] == 0), 64'(1));
        chk("wr_latency", 64'(lat[0]), 64'(80));
        chk("wr_frame",   64'(last_frame), 64'(40'h02_001234_A5));
        chk("wr_mem",     64'(mem.exists(24'h001234) ? mem[24'h001234] : 8'h00), 64'(8'hA5));

        // Read back via port 1; ack0 must stay quiet
        wr1 = 1'b0; addr1 = 24'h001234; wdata1 = 8'h00;
        run(0, 1, 0);
        chk("rd_grant",   64'(grants.size() == 1 && grants[0] == 1), 64'(1));
        chk("rd_latency", 64'(lat[0]), 64'(80));
        f = last_frame;
        chk("rd_frame",   64'(f[39:8]), 64'(32'h03_001234));
        chk("rd_data",    64'(rd_q[0]), 64'(8'hA5));

        // Tie from reset: port 0 first, then alternate
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        wr0 = 1'b1; addr0 = 24'h000100; wdata0 = 8'h5A;
        wr1 = 1'b0; addr1 = 24'h001234;
        run(2, 2, 0);
        order = 4'((grants[0] << 3) | (grants[1] << 2) | (grants[2] << 1) | grants[3]);
        chk("tie_count",  64'(grants.size()), 64'(4));
        chk("tie_order",  64'(order), 64'(4'b0101));
        chk("tie_cs_gap", 64'(min_hi >= 2), 64'(1));
        chk("tie_rd1",    64'(rd_q[1]), 64'(8'hA5));
        chk("tie_rd3",    64'(rd_q[3]), 64'(8'hA5));

        // Single requester held high: back-to-back grants to port 1
        wr1 = 1'b0; addr1 = 24'h000100;
        run(0, 2, 1);
        chk("single_order",   64'(grants.size() == 2 && grants[0] == 1 && grants[1] == 1), 64'(1));
        chk("single_spacing", 64'(falls[1] - falls[0]), 64'(82));
        chk("single_cs_gap",  64'(min_hi), 64'(2));
        chk("single_rd0",     64'(rd_q[0]), 64'(8'h5A));
        chk("single_rd1",     64'(rd_q[1]), 64'(8'h5A));

        // Reset at E40 of a write to 0x1234: aborted, nothing committed
        @(negedge clk);
        wr0 = 1'b1; addr0 = 24'h001234; wdata0 = 8'hEE; req0 = 1'b1;
        c = 0;
        while (cs_n && c < 50) begin @(negedge clk); c++; end
        chk("abort_grant", 64'(c < 50), 64'(1));
        repeat (40) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_cs_n",  64'(cs_n),  64'(1));
        chk("abort_sclk",  64'(sclk),  64'(0));
        chk("abort_mosi",  64'(mosi),  64'(0));
        chk("abort_rdata", 64'(rdata), 64'(0));
        req0 = 1'b0;
        @(negedge clk);
        chk("abort_no_ack", 64'(ack0), 64'(0));
        rst = 1'b0;
        wr0 = 1'b0;
        run(1, 0, 0);
        chk("reissue_latency", 64'(lat[0]), 64'(80));
        chk("reissue_rd",      64'(rd_q[0]), 64'(8'hA5));

        // Address extremes: no carry into the command byte
        wr0 = 1'b1; addr0 = 24'hFFFFFF; wdata0 = 8'hC3;
        run(1, 0, 0);
        chk("wrap_wr_frame", 64'(last_frame), 64'(40'h02_FFFFFF_C3));
        wr0 = 1'b0;
        run(1, 0, 0);
        f = last_frame;
        chk("wrap_rd_hi_frame", 64'(f[39:8]), 64'(32'h03_FFFFFF));
        chk("wrap_rd_hi_data",  64'(rd_q[0]), 64'(8'hC3));
        addr0 = 24'h000000;
        run(1, 0, 0);
        f = last_frame;
        chk("wrap_rd_lo_frame", 64'(f[39:8]), 64'(32'h03_000000));
        chk("wrap_rd_lo_data",  64'(rd_q[0]), 64'(8'h00));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_sram_arbiter.md
# spi_sram_arbiter

Two-port arbiter and single-byte SPI master for the external SPI SRAM. It sits between the CPU cache-fill port (port 0) and an auxiliary requester such as a loader or debug DMA (port 1). Each granted request is serialized as one SPI mode-0 READ (0x03) or WRITE (0x02) transaction with a 24-bit address and one data byte. It drives the `cs_n`, `mosi` and `sclk` pins and samples `miso`.

## Interface
- `CS_GAP`, default 1: minimum extra `clk` cycles spent in GAP after each transaction (legal range 1..15).
- `clk`  in  1  system clock; `sclk` runs at `clk`/2 during a transaction.
- `rst`  in  1  reset, asynchronous, active-high.
- `req0`, `req1`  in  1  request; held high until the matching `ack` pulse.
- `wr0`, `wr1`  in  1  1 = write, 0 = read.
- `addr0`, `addr1`  in  24  byte address.
- `wdata0`, `wdata1`  in  8  write data.
- `ack0`, `ack1`  out  1  one-cycle completion pulse.
- `rdata`  out  8  read byte; valid in the `ack` cycle and held until the next transaction's data phase.
- `cs_n`  out  1  SRAM chip select, active low.
- `mosi`  out  1  serial data out.
- `sclk`  out  1  SPI clock, idle low.
- `miso`  in  1  serial data in.

## Operation
- State machine states: IDLE, SELECT, HIGH, LOW, GAP.
- IDLE, arbitration:
  - If any request is pending: choose a winner, latch `{cmd, addr, wdata}` into a 40-bit shift register, latch the port id, go to SELECT.
  - `cmd` is 0x02 when `wr` = 1 and 0x03 otherwise.
- Arbitration rule is round-robin:
  - If only one request is pending, that port wins.
  - If both are pending, the port not granted last wins.
  - `last_grant` resets to 1, so port 0 wins the first tie.
- SELECT:
  - `cs_n` = 0, `sclk` = 0, `mosi` = shift register MSB (bit 39).
  - Lasts one cycle, then goes to HIGH.
- HIGH: `sclk` = 1; lasts one cycle, then goes to LOW.
- LOW:
  - On entry, if bit index i ≥ 32, sample `miso` into `rdata` LSB and shift left.
  - Shift the out-register left; `mosi` = new MSB; `sclk` = 0.
  - Increment the 6-bit bit counter.
  - If the counter reaches 40: `cs_n` = 1, pulse `ack` of the latched port, go to GAP. Otherwise go to HIGH.
- Data order is MSB first throughout; the command and address bits are sent regardless of direction.
- Write: the data byte is shifted out; `rdata` then holds whatever was on `miso` (don't care).
- GAP:
  - `cs_n` = 1, `sclk` = 0.
  - Counts `CS_GAP` cycles, then returns to IDLE.
- Request signals are sampled only in IDLE.
- Changing `addr`, `wr` or `wdata` while a request is in flight has no effect.
- Dropping `req` before `ack` (protocol violation): the transaction still completes and `ack` still pulses.

## Timing
- Reset values: `cs_n` = 1, `sclk` = 0, `mosi` = 0, `ack0` = `ack1` = 0, `rdata` = 0x00, state = IDLE, `last_grant` = 1.
- Let E0 be the `clk` edge at which IDLE grants. Then:
  - `cs_n` falls at E0.
  - `sclk` rises at E(2i+1) for bit i = 0..39, i.e. E1, E3, …, E79.
  - `sclk` falls at E(2i+2).
  - `mosi` changes only on `sclk` falling edges, plus at E0.
- `miso` is sampled at the falling edges E66, E68, …, E80, giving data bits 7..0.
- At E80: `cs_n` rises, `ack` goes high for exactly one cycle, and `rdata` is final.
- Request-to-ack latency is 80 cycles from the granting edge.
- The earliest next grant is E(81 + `CS_GAP`), so `cs_n` is high for at least `CS_GAP` + 1 cycles.
- A request raised in the same cycle as another port's `ack` is eligible at the next IDLE.
- Reset asserted mid-transaction:
  - Outputs go immediately to their reset values and no `ack` is issued.
  - The requester must re-issue after reset.

## Structure
- Package `spi_sram_pkg` holds:
  - `localparam` `CMD_READ` = 8'h03, `CMD_WRITE` = 8'h02, `ADDR_W` = 24, `XFER_BITS` = 40.
  - typedef enum `spi_state_t` {IDLE, SELECT, HIGH, LOW, GAP}.
- One sub-module, `spi_byte_xfer`, contains the SELECT/HIGH/LOW/GAP engine: start, 40-bit frame in, `rdata` out, done.
- The top level contains only the round-robin arbiter and the ack demux.

## Test plan
- Write via port 0: `req0`, `wr0` = 1, `addr0` = 0x001234, `wdata0` = 0xA5 -> `mosi` frame 0x02_001234_A5, `ack0` at E80, the SRAM model holds 0xA5 at 0x1234.
- Read via port 1 of the same address -> frame 0x03_001234_xx, `ack1` at E80, `rdata` = 0xA5, `ack0` stays 0.
- Tie: `req0` and `req1` raised in the same cycle, both from reset, each issuing 2 requests -> grant order 0, 1, 0, 1; `cs_n` is high ≥ 2 cycles between frames.
- Single requester: `req1` held continuously with `req0` = 0 -> back-to-back grants to port 1, with grant spacing 81 + `CS_GAP` cycles.
- Reset at E40 of a transaction -> `cs_n` = 1 and `sclk` = 0 immediately, no `ack`; after reset release, a re-issued read returns correct data.
- Address wrap check: read at 0xFFFFFF and at 0x000000 -> correct 24-bit address bits on `mosi`, with no carry into the command byte.
